ecc_scalar_mult_ctrl: RTL and testbench
=======================================

# ecc_scalar_mult_ctrl

Left-to-right double-and-add controller for 192-bit elliptic-curve scalar multiplication R = k·P over GF(p). Sits directly upstream of the point-doubling and point-addition units. It sequences them bit by bit over the scalar, feeds them the running accumulator and consumes their results. It owns no field arithmetic; both point units are instantiated beside it in the ECC top level.

## Interface
- WIDTH, 192, coordinate width
- KBITS, 192, scalar width; bit counter is $clog2(KBITS) bits
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  start request, sampled in IDLE only
- i_k  in  KBITS  scalar; must satisfy k < group order
- i_px, i_py  in  WIDTH  base point P; must not be infinity
- o_busy  out  1  high from the cycle after start acceptance until DONE inclusive
- o_done  out  1  one-cycle completion pulse
- o_rx, o_ry  out  WIDTH  result; held until the next accepted start
- o_dbl_start  out  1  one-cycle start pulse to the doubling unit
- o_dbl_x, o_dbl_y  out  WIDTH  accumulator R sent for doubling
- i_dbl_done  in  1  doubling complete, one-cycle pulse
- i_dbl_x, i_dbl_y  in  WIDTH  2R, valid with i_dbl_done
- o_add_start  out  1  one-cycle start pulse to the addition unit
- o_add_x1, o_add_y1, o_add_x2, o_add_y2  out  WIDTH  R and P
- i_add_done  in  1  addition complete, one-cycle pulse
- i_add_x, i_add_y  in  WIDTH  R+P, valid with i_add_done

## Operation
- Point at infinity is encoded as x = all-ones (INF_X), y = 0.
- Start acceptance: i_start in IDLE latches i_k, i_px and i_py into internal registers and sets idx = KBITS-1. All operand outputs are driven from registers and stay stable until DONE. i_start outside IDLE is ignored.
- States are IDLE, SCAN, DBL, DBL_WAIT, ADD, ADD_WAIT, NEXT and DONE.
- SCAN (one bit per cycle, skips leading zeros):
  - k[idx]=1: R←P. If idx=0 go to DONE; otherwise idx←idx-1 and go to DBL.
  - k[idx]=0 and idx=0: R←INF, go to DONE (k=0).
  - Otherwise: idx←idx-1, stay in SCAN.
- DBL:
  - If R=INF, skip doubling and go to DBL_WAIT's exit decision directly.
  - Otherwise pulse o_dbl_start and go to DBL_WAIT.
- DBL_WAIT: on i_dbl_done, R←(i_dbl_x,i_dbl_y). Then go to ADD if k[idx]=1, else NEXT.
- ADD:
  - If R=INF, set R←P and go to NEXT with no pulse.
  - Otherwise pulse o_add_start and go to ADD_WAIT.
- ADD_WAIT: on i_add_done, R←(i_add_x,i_add_y), go to NEXT.
- NEXT: if idx=0 go to DONE; else idx←idx-1, go to DBL.
- DONE: o_rx/o_ry←R, o_done=1 for one cycle, go to IDLE.
- Done pulses arriving in any state other than the matching WAIT state are ignored.
- Equal-point and inverse-point cases are the addition unit's responsibility. With k below the group order, the controller never presents R=P.

## Timing
- Reset values: every output is 0, state is IDLE, R is INF, idx is 0.
- Reset mid-operation returns to IDLE immediately. No start pulse is emitted after reset, and a late done pulse from a sub-unit is ignored.
- Latency, measured from the start-sampling edge:
  - SCAN takes (KBITS - msb(k)) cycles.
  - Each remaining bit costs DBL (1) + doubling latency + 1.
  - Each remaining 1-bit additionally costs ADD (1) + addition latency + 1.
  - NEXT costs 1 per remaining bit; DONE costs 1.
- Example, k=1 with KBITS=192: o_done is high in cycle 193.
- o_dbl_start and o_add_start are single-cycle pulses and are never high together.
- At most one sub-unit operation is outstanding at any time.
- o_busy deasserts in the cycle after o_done.

## Structure
- Shared package ecc_pkg holds:
  - WIDTH
  - INF_X (all-ones) and INF_Y (0)
  - the 3-bit state encoding for the eight states
  - an is_inf function
- No internal sub-module. The point-doubling and point-addition units are external siblings, wired by ecc_scalar_mult_top.

## Test plan
Sub-units are stubs with programmable latency (doubling 5, addition 7) that return tagged values.
- k=0 -> o_done at cycle 193; o_rx = all-ones, o_ry = 0; no dbl or add pulses.
- k=1, P=(0x11,0x22) -> o_done at cycle 193; result (0x11,0x22); no sub-unit pulses.
- k=2 -> exactly one o_dbl_start with operands (0x11,0x22) and no add; result equals the stub doubling output.
- k=3 -> one dbl, then one add with x1/y1 = doubling output and x2/y2 = P; result equals the stub addition output.
- k=0x5 -> pulse sequence dbl, dbl, add. Then assert i_start mid-run: it is ignored, operands stay stable and the result is unchanged.
- k=0xFF..FF, assert i_rst during ADD_WAIT -> all outputs 0 next cycle; the stub's late i_add_done is ignored; a fresh start then runs correctly.

Source files
------------

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared ECC widths, point-at-infinity encoding and controller state encoding
package ecc_pkg;

  localparam int WIDTH = 192;

  // Point at infinity: x all-ones, y zero
  localparam logic [WIDTH-1:0] INF_X = '1;
  localparam logic [WIDTH-1:0] INF_Y = '0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SCAN     = 3'd1,
    ST_DBL      = 3'd2,
    ST_DBL_WAIT = 3'd3,
    ST_ADD      = 3'd4,
    ST_ADD_WAIT = 3'd5,
    ST_NEXT     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  function automatic logic is_inf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x == INF_X) && (y == INF_Y);
  endfunction

endpackage

// File: rtl/ecc_scalar_mult_ctrl_if.sv
// rtl/ecc_scalar_mult_ctrl_if.sv - handshake bus between the scalar-mult controller and the point units
interface ecc_scalar_mult_ctrl_if;
  import ecc_pkg::*;

  // Doubling unit: R out, 2R back
  logic             o_dbl_start;
  logic [WIDTH-1:0] o_dbl_x;
  logic [WIDTH-1:0] o_dbl_y;
  logic             i_dbl_done;
  logic [WIDTH-1:0] i_dbl_x;
  logic [WIDTH-1:0] i_dbl_y;

  // Addition unit: R and P out, R+P back
  logic             o_add_start;
  logic [WIDTH-1:0] o_add_x1;
  logic [WIDTH-1:0] o_add_y1;
  logic [WIDTH-1:0] o_add_x2;
  logic [WIDTH-1:0] o_add_y2;
  logic             i_add_done;
  logic [WIDTH-1:0] i_add_x;
  logic [WIDTH-1:0] i_add_y;

  modport master (
    output o_dbl_start, o_dbl_x, o_dbl_y,
    input  i_dbl_done, i_dbl_x, i_dbl_y,
    output o_add_start, o_add_x1, o_add_y1, o_add_x2, o_add_y2,
    input  i_add_done, i_add_x, i_add_y
  );

  modport slave (
    input  o_dbl_start, o_dbl_x, o_dbl_y,
    output i_dbl_done, i_dbl_x, i_dbl_y,
    input  o_add_start, o_add_x1, o_add_y1, o_add_x2, o_add_y2,
    output i_add_done, i_add_x, i_add_y
  );

endinterface

// File: rtl/ecc_scalar_mult_ctrl.sv
// rtl/ecc_scalar_mult_ctrl.sv - left-to-right double-and-add sequencer for R = k*P
module ecc_scalar_mult_ctrl
  import ecc_pkg::*;
#(
  parameter int KBITS = 192
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [KBITS-1:0]       i_k,
  input  logic [WIDTH-1:0]       i_px,
  input  logic [WIDTH-1:0]       i_py,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [WIDTH-1:0]       o_rx,
  output logic [WIDTH-1:0]       o_ry,
  ecc_scalar_mult_ctrl_if.master pt
);

  localparam int IW = $clog2(KBITS);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [KBITS-1:0] k_q, k_d;
  logic [WIDTH-1:0] px_q, px_d, py_q, py_d;
  // Running accumulator R
  logic [WIDTH-1:0] r_x_q, r_x_d, r_y_q, r_y_d;
  // Registered result and operand outputs
  logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [WIDTH-1:0] dbl_x_q, dbl_x_d, dbl_y_q, dbl_y_d;
  logic [WIDTH-1:0] add_x1_q, add_x1_d, add_y1_q, add_y1_d;
  logic [WIDTH-1:0] add_x2_q, add_x2_d, add_y2_q, add_y2_d;
  logic             dbl_start, add_start;

  // Next-state, datapath updates and start pulses
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    px_d      = px_q;
    py_d      = py_q;
    r_x_d     = r_x_q;
    r_y_d     = r_y_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    dbl_x_d   = dbl_x_q;
    dbl_y_d   = dbl_y_q;
    add_x1_d  = add_x1_q;
    add_y1_d  = add_y1_q;
    add_x2_d  = add_x2_q;
    add_y2_d  = add_y2_q;
    dbl_start = 1'b0;
    add_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          k_d     = i_k;
          px_d    = i_px;
          py_d    = i_py;
          r_x_d   = INF_X;
          r_y_d   = INF_Y;
          idx_d   = IW'(KBITS - 1);
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (k_q[idx_q]) begin
          // First set bit: R starts as P, doubling begins with the next bit
          r_x_d = px_q;
          r_y_d = py_q;
          if (idx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q - IW'(1);
            state_d = ST_DBL;
          end
        end else if (idx_q == '0) begin
          r_x_d   = INF_X;
          r_y_d   = INF_Y;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      ST_DBL: begin
        if (is_inf(r_x_q, r_y_q)) begin
          state_d = k_q[idx_q] ? ST_ADD : ST_NEXT;
        end else begin
          dbl_start = 1'b1;
          state_d   = ST_DBL_WAIT;
        end
      end
      ST_DBL_WAIT: begin
        if (pt.i_dbl_done) begin
          r_x_d   = pt.i_dbl_x;
          r_y_d   = pt.i_dbl_y;
          state_d = k_q[idx_q] ? ST_ADD : ST_NEXT;
        end
      end
      ST_ADD: begin
        if (is_inf(r_x_q, r_y_q)) begin
          r_x_d   = px_q;
          r_y_d   = py_q;
          state_d = ST_NEXT;
        end else begin
          add_start = 1'b1;
          state_d   = ST_ADD_WAIT;
        end
      end
      ST_ADD_WAIT: begin
        if (pt.i_add_done) begin
          r_x_d   = pt.i_add_x;
          r_y_d   = pt.i_add_y;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = ST_DBL;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Operands are captured on entry so they are valid alongside the start pulse
    if (state_d == ST_DBL && state_q != ST_DBL) begin
      dbl_x_d = r_x_d;
      dbl_y_d = r_y_d;
    end
    if (state_d == ST_ADD && state_q != ST_ADD) begin
      add_x1_d = r_x_d;
      add_y1_d = r_y_d;
      add_x2_d = px_q;
      add_y2_d = py_q;
    end
    // Result is published on entry to DONE so it is valid with o_done
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      rx_d = r_x_d;
      ry_d = r_y_d;
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      k_q      <= '0;
      px_q     <= '0;
      py_q     <= '0;
      r_x_q    <= INF_X;
      r_y_q    <= INF_Y;
      rx_q     <= '0;
      ry_q     <= '0;
      dbl_x_q  <= '0;
      dbl_y_q  <= '0;
      add_x1_q <= '0;
      add_y1_q <= '0;
      add_x2_q <= '0;
      add_y2_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      px_q     <= px_d;
      py_q     <= py_d;
      r_x_q    <= r_x_d;
      r_y_q    <= r_y_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      dbl_x_q  <= dbl_x_d;
      dbl_y_q  <= dbl_y_d;
      add_x1_q <= add_x1_d;
      add_y1_q <= add_y1_d;
      add_x2_q <= add_x2_d;
      add_y2_q <= add_y2_d;
    end
  end

  assign o_busy         = (state_q != ST_IDLE);
  assign o_done         = (state_q == ST_DONE);
  assign o_rx           = rx_q;
  assign o_ry           = ry_q;
  assign pt.o_dbl_start = dbl_start;
  assign pt.o_dbl_x     = dbl_x_q;
  assign pt.o_dbl_y     = dbl_y_q;
  assign pt.o_add_start = add_start;
  assign pt.o_add_x1    = add_x1_q;
  assign pt.o_add_y1    = add_y1_q;
  assign pt.o_add_x2    = add_x2_q;
  assign pt.o_add_y2    = add_y2_q;

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// tb/tb_ecc_scalar_mult_ctrl.sv - directed vector bench for ecc_scalar_mult_ctrl with latency stubs
module tb_ecc_scalar_mult_ctrl;
  import ecc_pkg::*;

  localparam int DLAT = 5;
  localparam int ALAT = 7;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [191:0]     i_k;
  logic [WIDTH-1:0] i_px, i_py;
  logic             o_busy, o_done;
  logic [WIDTH-1:0] o_rx, o_ry;

  ecc_scalar_mult_ctrl_if pt_if();

  ecc_scalar_mult_ctrl #(.KBITS(192)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_k     (i_k),
    .i_px    (i_px),
    .i_py    (i_py),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_rx    (o_rx),
    .o_ry    (o_ry),
    .pt      (pt_if)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Stub bookkeeping
  int           n_dbl, n_add;
  int           ops[$];
  logic [191:0] dlog_x[$], dlog_y[$], alog_x1[$], alog_x2[$], alog_y2[$];

  typedef struct {
    logic [191:0] k;
    logic [191:0] px;
    logic [191:0] py;
    logic [191:0] rx;
    logic [191:0] ry;
    int           cyc;
    int           ndbl;
    int           nadd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Doubling stub adds (0x1000,0x2000); addition stub returns (x1+x2, y1+y2+5)
  initial begin : stubs
    int           dcnt, acnt;
    logic [191:0] dx, dy, ax1, ay1, ax2, ay2;
    dcnt = 0;
    acnt = 0;
    pt_if.i_dbl_done = 1'b0;
    pt_if.i_dbl_x    = '0;
    pt_if.i_dbl_y    = '0;
    pt_if.i_add_done = 1'b0;
    pt_if.i_add_x    = '0;
    pt_if.i_add_y    = '0;
    forever begin
      @(posedge i_clk);
      #1;
      pt_if.i_dbl_done = 1'b0;
      pt_if.i_add_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          pt_if.i_dbl_done = 1'b1;
          pt_if.i_dbl_x    = dx + 192'h1000;
          pt_if.i_dbl_y    = dy + 192'h2000;
        end
      end
      if (acnt > 0) begin
        acnt--;
        if (acnt == 0) begin
          pt_if.i_add_done = 1'b1;
          pt_if.i_add_x    = ax1 + ax2;
          pt_if.i_add_y    = ay1 + ay2 + 192'h5;
        end
      end
      if (pt_if.o_dbl_start || pt_if.o_add_start) begin
        chk("pulse_exclusive", {pt_if.o_dbl_start, pt_if.o_add_start} == 2'b11, 1'b0);
        chk("one_outstanding", (dcnt != 0) || (acnt != 0), 1'b0);
      end
      if (pt_if.o_dbl_start) begin
        dx = pt_if.o_dbl_x;
        dy = pt_if.o_dbl_y;
        dcnt = DLAT + 1;
        n_dbl++;
        ops.push_back(0);
        dlog_x.push_back(dx);
        dlog_y.push_back(dy);
      end
      if (pt_if.o_add_start) begin
        ax1 = pt_if.o_add_x1;
        ay1 = pt_if.o_add_y1;
        ax2 = pt_if.o_add_x2;
        ay2 = pt_if.o_add_y2;
        acnt = ALAT + 1;
        n_add++;
        ops.push_back(1);
        alog_x1.push_back(ax1);
        alog_x2.push_back(ax2);
        alog_y2.push_back(ay2);
      end
    end
  end

  task automatic clear_logs();
    n_dbl = 0;
    n_add = 0;
    ops.delete();
    dlog_x.delete();
    dlog_y.delete();
    alog_x1.delete();
    alog_x2.delete();
    alog_y2.delete();
  endtask

  // Runs one multiplication; optionally pulses a conflicting start at cycle inj
  task automatic run_mult(input logic [191:0] k, input logic [191:0] px, input logic [191:0] py,
                          input int inj, output int cyc, output bit done_seen);
    clear_logs();
    @(posedge i_clk);
    #1;
    i_k = k;
    i_px = px;
    i_py = py;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    cyc = 1;
    while (!o_done && cyc < 5000) begin
      if (cyc == inj) begin
        i_start = 1'b1;
        i_k = '1;
        i_px = 192'h77;
        i_py = 192'h88;
      end else begin
        i_start = 1'b0;
      end
      @(posedge i_clk);
      #1;
      cyc++;
    end
    i_start = 1'b0;
    done_seen = o_done;
    if (!done_seen) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no o_done expected o_done within 5000 cycles");
    end
  endtask

  task automatic do_vec(input int i, input int inj);
    int cyc;
    bit ok;
    run_mult(vecs[i].k, vecs[i].px, vecs[i].py, inj, cyc, ok);
    if (ok) begin
      chk($sformatf("v%0d_rx", i), o_rx, vecs[i].rx);
      chk($sformatf("v%0d_ry", i), o_ry, vecs[i].ry);
      chk_int($sformatf("v%0d_done_cycle", i), cyc, vecs[i].cyc);
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d_busy_after", i), o_busy, 1'b0);
      chk($sformatf("v%0d_rx_held", i), o_rx, vecs[i].rx);
      chk_int($sformatf("v%0d_ndbl", i), n_dbl, vecs[i].ndbl);
      chk_int($sformatf("v%0d_nadd", i), n_add, vecs[i].nadd);
      if (dlog_x.size() > 0) begin
        chk($sformatf("v%0d_dbl0_x", i), dlog_x[0], vecs[i].px);
        chk($sformatf("v%0d_dbl0_y", i), dlog_y[0], vecs[i].py);
      end
      if (alog_x2.size() > 0) begin
        chk($sformatf("v%0d_add0_x2", i), alog_x2[0], vecs[i].px);
        chk($sformatf("v%0d_add0_y2", i), alog_y2[0], vecs[i].py);
      end
    end
  endtask

  initial begin : main
    bit saw_activity;
    int w, nd, na;

    //          k                   px       py       rx            ry            cyc   ndbl nadd
    vecs[0] = '{192'h0,             192'h11, 192'h22, '1,           192'h0,        193,   0,   0};
    vecs[1] = '{192'h1,             192'h11, 192'h22, 192'h11,      192'h22,       193,   0,   0};
    vecs[2] = '{192'h2,             192'h11, 192'h22, 192'h1011,    192'h2022,     200,   1,   0};
    vecs[3] = '{192'h3,             192'h11, 192'h22, 192'h1022,    192'h2049,     209,   1,   1};
    vecs[4] = '{192'h6,             192'hA,  192'hB,  192'h2014,    192'h401B,     216,   2,   1};
    vecs[5] = '{192'h1 << 191,      192'h11, 192'h22, 192'hBF011,   192'h17E022,  1530, 191,   0};

    i_rst = 1'b1;
    i_start = 1'b0;
    i_k = '0;
    i_px = '0;
    i_py = '0;
    clear_logs();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_rx", o_rx, '0);
    chk("rst_ry", o_ry, '0);
    chk("rst_pulses", {pt_if.o_dbl_start, pt_if.o_add_start}, 2'b00);
    chk("rst_dbl_ops", {pt_if.o_dbl_x, pt_if.o_dbl_y}, '0);
    chk("rst_add_ops", {pt_if.o_add_x1, pt_if.o_add_y1, pt_if.o_add_x2, pt_if.o_add_y2}, '0);
    i_rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_vec(i, 0);
    end

    // k=3 operand routing: add gets 2P as R and P as second operand
    do_vec(3, 0);
    if (alog_x1.size() > 0) chk("k3_add_x1", alog_x1[0], 192'h1011);

    // k=5 with a start injected during the first doubling wait
    begin
      int cyc;
      bit ok;
      run_mult(192'h5, 192'h11, 192'h22, 194, cyc, ok);
      if (ok) begin
        chk("k5_rx", o_rx, 192'h2022);
        chk("k5_ry", o_ry, 192'h4049);
        chk_int("k5_done_cycle", cyc, 216);
        chk_int("k5_nops", ops.size(), 3);
        if (ops.size() == 3) begin
          chk_int("k5_seq", ops[0] * 100 + ops[1] * 10 + ops[2], 1);
          chk("k5_dbl1_x", dlog_x[1], 192'h1011);
          chk("k5_add_x1", alog_x1[0], 192'h2011);
          chk("k5_add_x2", alog_x2[0], 192'h11);
        end
      end
      @(posedge i_clk);
      #1;
      chk("k5_idle_after", o_busy, 1'b0);
    end

    // k all-ones, reset while the addition is outstanding
    clear_logs();
    @(posedge i_clk);
    #1;
    i_k = '1;
    i_px = 192'h11;
    i_py = 192'h22;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    w = 0;
    while (n_add < 1 && w < 2000) begin
      @(posedge i_clk);
      #1;
      w++;
    end
    chk_int("rst_mid_reached_add", n_add, 1);
    @(posedge i_clk);
    #1;
    chk("rst_mid_busy_before", o_busy, 1'b1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst_mid_busy", o_busy, 1'b0);
    chk("rst_mid_done", o_done, 1'b0);
    chk("rst_mid_rx", {o_rx, o_ry}, '0);
    chk("rst_mid_ops", {pt_if.o_dbl_x, pt_if.o_dbl_y, pt_if.o_add_x1, pt_if.o_add_y1,
                        pt_if.o_add_x2, pt_if.o_add_y2}, '0);
    chk("rst_mid_pulses", {pt_if.o_dbl_start, pt_if.o_add_start}, 2'b00);
    i_rst = 1'b0;
    nd = n_dbl;
    na = n_add;
    saw_activity = 1'b0;
    repeat (12) begin
      @(posedge i_clk);
      #1;
      if (o_busy || o_done || pt_if.o_dbl_start || pt_if.o_add_start) saw_activity = 1'b1;
    end
    chk("rst_late_done_ignored", saw_activity, 1'b0);
    chk_int("rst_no_new_pulses", (n_dbl - nd) + (n_add - na), 0);

    do_vec(3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
